// File: rtl/led_digit_scan_pkg.sv
// led_digit_scan shared definitions: digit count, anode levels,
// nibble width, default timing and display helper functions.
package led_digit_scan_pkg;

    localparam int LED_DIGITS = 4;
    localparam int LED_NIBBLE_W = 4;
    localparam logic [3:0] LED_ANODE_OFF = 4'b1111;

    localparam int LED_DIV_DEFAULT = 50000;
    localparam int LED_DEAD_DEFAULT = 16;

    typedef logic [LED_NIBBLE_W-1:0] nibble_t;
    typedef logic [1:0] digitIdx_t;

    // Nibble of a 16-bit display word selected by digit index.
    function automatic nibble_t nibbleAt(
        input logic [15:0] v,
        input digitIdx_t i
    );
        return v[LED_NIBBLE_W*i +: LED_NIBBLE_W];
    endfunction

    // Leading-zero blank mask; digit 0 is never blanked.
    function automatic logic [3:0] leadingBlank(
        input logic [15:0] v,
        input logic [3:0] d
    );
        logic [3:0] blank;
        logic zeroAbove;
        blank = '0;
        zeroAbove = 1'b1;
        for (int i = LED_DIGITS - 1; i >= 1; i--) begin
            zeroAbove = zeroAbove && (v[LED_NIBBLE_W*i +: LED_NIBBLE_W] == '0);
            blank[i] = zeroAbove && !d[i];
        end
        return blank;
    endfunction

endpackage

// File: rtl/led_digit_scan_if.sv
// led_digit_scan bus: display load side plus scan outputs.
// master drives value/load/dpIn; slave drives the digit outputs.
interface led_digit_scan_if;
    import led_digit_scan_pkg::*;

    logic [15:0] value;
    logic load;
    logic [3:0] dpIn;
    nibble_t N;
    logic [3:0] anode;
    logic dp;
    logic frame;

    modport master (
        output value, load, dpIn,
        input N, anode, dp, frame
    );

    modport slave (
        input value, load, dpIn,
        output N, anode, dp, frame
    );

endinterface

// File: rtl/led_digit_scan_prescaler.sv
// scan_prescaler: modulo-DIV slot counter with end-of-slot tick.
// cntNext is exported so the top can register outputs from next state.
module scan_prescaler #(
    parameter int DIV = 8,
    parameter int CW = $clog2(DIV)
) (
    input  logic clk,
    input  logic rst,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] cntNext,
    output logic tick
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    assign tick = (cnt == LAST);
    assign cntNext = tick ? '0 : cnt + CW'(1);

    // Slot counter wraps to 0 after DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cntNext;
        end
    end

endmodule

// File: rtl/led_digit_scan.sv
// led_digit_scan: 4-digit multiplexed scan with dead time and frame-aligned loads.
// Optional macro LED_SCAN_ZERO_BLANK_EN enables leading-zero blanking.
module led_digit_scan
    import led_digit_scan_pkg::*;
#(
    parameter int DIV = LED_DIV_DEFAULT,
    parameter int DEAD = LED_DEAD_DEFAULT
) (
    input logic clk,
    input logic rst,
    led_digit_scan_if.slave bus
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] DEADC = CW'(DEAD);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cntNext;
    logic tick;

    digitIdx_t idx;
    digitIdx_t idxNext;

    logic [15:0] dispVal;
    logic [3:0] dispDp;
    logic [15:0] shadowVal;
    logic [3:0] shadowDp;
    logic pending;

    logic [15:0] dispValNext;
    logic [3:0] dispDpNext;
    logic [15:0] shadowValNext;
    logic [3:0] shadowDpNext;
    logic pendingNext;

    logic boundary;
    logic live;
    logic [3:0] blankNext;
    logic [3:0] anodeNext;

    scan_prescaler #(
        .DIV(DIV),
        .CW(CW)
    ) uPrescaler (
        .clk(clk),
        .rst(rst),
        .cnt(cnt),
        .cntNext(cntNext),
        .tick(tick)
    );

    generate
        if (DEAD == 0) begin : gNoDead
            assign live = 1'b1;
        end else begin : gDead
            assign live = (cntNext >= DEADC);
        end
    endgenerate

    // Next-state for digit index, shadow and display registers.
    always_comb begin
        boundary = tick && (idx == 2'd3);
        idxNext = tick ? idx + 2'd1 : idx;

        shadowValNext = shadowVal;
        shadowDpNext = shadowDp;
        pendingNext = pending;
        dispValNext = dispVal;
        dispDpNext = dispDp;

        if (bus.load) begin
            shadowValNext = bus.value;
            shadowDpNext = bus.dpIn;
            pendingNext = 1'b1;
        end

        if (boundary) begin
            if (bus.load) begin
                dispValNext = bus.value;
                dispDpNext = bus.dpIn;
            end else if (pending) begin
                dispValNext = shadowVal;
                dispDpNext = shadowDp;
            end
            pendingNext = 1'b0;
        end
    end

    // Anode pattern for the next state, honouring dead time and blanking.
    always_comb begin
`ifdef LED_SCAN_ZERO_BLANK_EN
        blankNext = leadingBlank(dispValNext, dispDpNext);
`else
        blankNext = '0;
`endif
        anodeNext = LED_ANODE_OFF;
        if (live) begin
            anodeNext = ~((4'b0001 << idxNext) & ~blankNext);
        end
    end

    // Scan state and load registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            dispVal <= '0;
            dispDp <= '0;
            shadowVal <= '0;
            shadowDp <= '0;
            pending <= 1'b0;
        end else begin
            idx <= idxNext;
            dispVal <= dispValNext;
            dispDp <= dispDpNext;
            shadowVal <= shadowValNext;
            shadowDp <= shadowDpNext;
            pending <= pendingNext;
        end
    end

    // Registered outputs derived from next state so they track the registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.N <= '0;
            bus.anode <= LED_ANODE_OFF;
            bus.dp <= 1'b0;
            bus.frame <= 1'b0;
        end else begin
            bus.N <= nibbleAt(dispValNext, idxNext);
            bus.anode <= anodeNext;
            bus.dp <= dispDpNext[idxNext];
            bus.frame <= boundary;
        end
    end

endmodule

// File: tb/tb_led_digit_scan.sv
// Testbench for led_digit_scan: table-driven frame checks, corner
// sequences and randomized loads against a time-based reference model.
module tb_led_digit_scan;

    localparam int DIV = 8;
    localparam int DEAD = 2;

    typedef struct {
        logic [3:0] n;
        logic [3:0] an;
        logic dp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    led_digit_scan_if bus();

    led_digit_scan #(
        .DIV(DIV),
        .DEAD(DEAD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    int mT;
    logic [15:0] mDisp;
    logic [15:0] mShadow;
    logic [3:0] mDispDp;
    logic [3:0] mShadowDp;
    bit mPend;
    bit mFrame;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mT = 0;
        mDisp = '0;
        mShadow = '0;
        mDispDp = '0;
        mShadowDp = '0;
        mPend = 0;
        mFrame = 0;
    endtask

    function automatic bit mBlanked(input int i);
`ifdef LED_SCAN_ZERO_BLANK_EN
        if (i == 0) return 0;
        return ((mDisp >> (4 * i)) == 0) && !mDispDp[i];
`else
        return (i < 0);
`endif
    endfunction

    // One clock edge in the spec's terms: time since reset decides slot/boundary.
    task automatic modelStep(input bit ld, input logic [15:0] v, input logic [3:0] d);
        bit bnd;
        bnd = (mT % DIV == DIV - 1) && ((mT / DIV) % 4 == 3);
        if (bnd) begin
            if (ld) begin
                mDisp = v;
                mDispDp = d;
            end else if (mPend) begin
                mDisp = mShadow;
                mDispDp = mShadowDp;
            end
            mPend = 0;
        end else if (ld) begin
            mShadow = v;
            mShadowDp = d;
            mPend = 1;
        end
        mFrame = bnd;
        mT++;
    endtask

    task automatic modelCompare();
        int c;
        int ix;
        logic [3:0] eN;
        logic [3:0] eAn;
        logic eDp;
        c = mT % DIV;
        ix = (mT / DIV) % 4;
        eN = 4'((mDisp >> (4 * ix)) & 16'hF);
        eDp = mDispDp[ix];
        eAn = 4'b1111;
        if (c >= DEAD && !mBlanked(ix)) eAn[ix] = 1'b0;
        check("model", {bus.N, bus.anode, bus.dp, bus.frame}, {eN, eAn, eDp, mFrame});
    endtask

    task automatic cycle(input bit ld, input logic [15:0] v, input logic [3:0] d);
        bus.load = ld;
        bus.value = v;
        bus.dpIn = d;
        @(posedge clk);
        modelStep(ld, v, d);
        #1;
        modelCompare();
        bus.load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 16'h0, 4'h0);
    endtask

    task automatic waitFrame();
        bit ok;
        ok = 0;
        for (int i = 0; i < 4 * DIV + 2 && !ok; i++) begin
            cycle(0, 16'h0, 4'h0);
            if (bus.frame === 1'b1) ok = 1;
        end
        check("frameSeen", 32'(ok), 32'd1);
    endtask

    // Runs one frame from slot 0, cnt 0; checks mid-slot outputs and anode duty.
    task automatic runFrame(input vec_t tab[4], input string tag);
        int low[4];
        for (int i = 0; i < 4; i++) low[i] = 0;
        for (int k = 0; k < 4 * DIV; k++) begin
            for (int i = 0; i < 4; i++) if (bus.anode[i] === 1'b0) low[i]++;
            if (k % DIV == DIV / 2) begin
                check(tag, {bus.N, bus.anode, bus.dp},
                      {tab[k / DIV].n, tab[k / DIV].an, tab[k / DIV].dp});
            end
            cycle(0, 16'h0, 4'h0);
        end
        for (int i = 0; i < 4; i++) begin
            check({tag, "Duty"}, 32'(low[i]),
                  (tab[i].an == 4'b1111) ? 32'd0 : 32'(DIV - DEAD));
        end
    endtask

    vec_t scanTab[4];
    vec_t twoTab[4];
    vec_t beefTab[4];
    vec_t zeroTab[4];
    vec_t nullTab[4];

    initial begin
        scanTab[0] = '{4'hF, 4'b1110, 1'b0};
        scanTab[1] = '{4'h2, 4'b1101, 1'b0};
        scanTab[2] = '{4'hA, 4'b1011, 1'b1};
        scanTab[3] = '{4'h1, 4'b0111, 1'b0};

        twoTab[0] = '{4'h2, 4'b1110, 1'b0};
        twoTab[1] = '{4'h2, 4'b1101, 1'b0};
        twoTab[2] = '{4'h2, 4'b1011, 1'b0};
        twoTab[3] = '{4'h2, 4'b0111, 1'b0};

        beefTab[0] = '{4'hF, 4'b1110, 1'b0};
        beefTab[1] = '{4'hE, 4'b1101, 1'b0};
        beefTab[2] = '{4'hE, 4'b1011, 1'b0};
        beefTab[3] = '{4'hB, 4'b0111, 1'b0};

        zeroTab[0] = '{4'h7, 4'b1110, 1'b0};
`ifdef LED_SCAN_ZERO_BLANK_EN
        zeroTab[1] = '{4'h0, 4'b1111, 1'b0};
        zeroTab[2] = '{4'h0, 4'b1111, 1'b0};
        zeroTab[3] = '{4'h0, 4'b1111, 1'b0};
`else
        zeroTab[1] = '{4'h0, 4'b1101, 1'b0};
        zeroTab[2] = '{4'h0, 4'b1011, 1'b0};
        zeroTab[3] = '{4'h0, 4'b0111, 1'b0};
`endif

        nullTab[0] = '{4'h0, 4'b1110, 1'b0};
`ifdef LED_SCAN_ZERO_BLANK_EN
        nullTab[1] = '{4'h0, 4'b1111, 1'b0};
        nullTab[2] = '{4'h0, 4'b1111, 1'b0};
        nullTab[3] = '{4'h0, 4'b1111, 1'b0};
`else
        nullTab[1] = '{4'h0, 4'b1101, 1'b0};
        nullTab[2] = '{4'h0, 4'b1011, 1'b0};
        nullTab[3] = '{4'h0, 4'b0111, 1'b0};
`endif

        bus.value = '0;
        bus.load = 1'b0;
        bus.dpIn = '0;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        check("rstOut", {bus.N, bus.anode, bus.dp, bus.frame}, {4'h0, 4'b1111, 1'b0, 1'b0});
        rst = 1'b0;
        modelReset();

        // First anode once cnt reaches DEAD.
        cycle(0, 16'h0, 4'h0);
        check("deadAn", {28'h0, bus.anode}, 32'h0000_000F);
        cycle(0, 16'h0, 4'h0);
        check("firstAn", {28'h0, bus.anode}, 32'h0000_000E);

        // Scan of 1A2F with dp on digit 2.
        cycle(1, 16'h1A2F, 4'b0100);
        waitFrame();
        runFrame(scanTab, "scan");

        // Double load within a frame: newest wins.
        cycle(1, 16'h1111, 4'h0);
        idle(4);
        cycle(1, 16'h2222, 4'h0);
        waitFrame();
        runFrame(twoTab, "dbl");

        // Load on the boundary edge discards older shadow contents.
        cycle(1, 16'h1234, 4'h0);
        idle(4 * DIV - 2);
        cycle(1, 16'hBEEF, 4'h0);
        check("bndFrame", {31'h0, bus.frame}, 32'd1);
        check("bndN", {28'h0, bus.N}, 32'h0000_000F);
        check("bndPend", {31'h0, dut.pending}, 32'd0);
        runFrame(beefTab, "bnd");

        // Leading zeros.
        cycle(1, 16'h0007, 4'h0);
        waitFrame();
        runFrame(zeroTab, "zero");

        // Asynchronous reset in slot 2 with a pending load.
        cycle(1, 16'h5555, 4'hF);
        idle(2 * DIV);
        rst = 1'b1;
        #1;
        check("asyncRst", {bus.N, bus.anode, bus.dp, bus.frame}, {4'h0, 4'b1111, 1'b0, 1'b0});
        check("asyncPend", {31'h0, dut.pending}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        waitFrame();
        runFrame(nullTab, "postRst");

        // Randomized loads against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                cycle(1, 16'($urandom), 4'($urandom));
            end else begin
                cycle(0, 16'h0, 4'h0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_digit_scan.md
# led_digit_scan

Time-multiplexed 4-digit scan controller feeding the hex-to-seven-segment decoder `LED`. It holds a 16-bit display value and cycles through its four nibbles: it drives the decoder's 4-bit `N` input and the matching active-low digit anode. It also applies a dead-time gap between digits to suppress ghosting. New values are applied only at frame boundaries, so a digit never tears mid-frame.

## Interface
- `DIV`, default 50000: clock cycles per digit slot; legal range 2..2^20.
- `DEAD`, default 16: cycles at the start of each slot with all anodes off; must satisfy 0 ≤ DEAD < DIV.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: reset. Asynchronous, active-high.
- `value`, input, 16: value to display. Bits [3:0] go to digit 0 (rightmost).
- `load`, input, 1: when high on an edge, `value` is captured into the shadow register.
- `dpIn`, input, 4: per-digit decimal point, active-high. Captured together with `value`.
- `N`, output, 4: nibble for the current digit; connects to the decoder's `N`.
- `anode`, output, 4: digit enables, active-low. Bit i drives digit i.
- `dp`, output, 1: decimal point for the current digit, active-high.
- `frame`, output, 1: one-cycle pulse when digit 3's slot ends and the display register updates.

## Operation
- Prescaler `cnt` counts 0..DIV-1. On the edge where `cnt == DIV-1`:
  - `cnt` returns to 0.
  - Digit index `idx` advances 0→1→2→3→0.
- Shadow register `{shadowVal, shadowDp}` and a `pending` flag:
  - On an edge with `load=1`: capture `value`/`dpIn` and set `pending`.
  - If `load` repeats before the boundary, the newest value wins.
- Frame boundary is the edge with `cnt == DIV-1` and `idx == 3`. On that edge:
  - If `pending`: `dispVal`/`dispDp` take the shadow contents and `pending` clears.
  - `frame` pulses high for one cycle.
- `load` on the boundary edge: `value`/`dpIn` go directly into `dispVal`/`dispDp` and `pending` ends at 0. Any older shadow value is discarded.
- Outputs, registered; each is computed from the next-state `cnt`/`idx`/`dispVal`, so it always matches the current register state:
  - `N` = `dispVal[4*idx+3 : 4*idx]`.
  - `dp` = `dispDp[idx]`.
  - `anode[i]` = 0 only when `i == idx`, `cnt ≥ DEAD`, and digit i is not blanked. Otherwise 1.
- No handshake back-pressure: `load` is always accepted.

## Timing
- Reset values: `cnt=0`, `idx=0`, `dispVal=0`, `dispDp=0`, shadow=0, `pending=0`, `N=0`, `anode=4'b1111`, `dp=0`, `frame=0`.
- First anode after reset: `anode` goes to 4'b1110 on the edge where `cnt` becomes DEAD. With DEAD=0 it is asserted from the first slot (cycle 0).
- Slot length is exactly DIV cycles. A full frame is 4·DIV cycles.
- Load-to-display latency: up to 4·DIV cycles, always at a boundary.
- When `rst` asserts mid-frame, all outputs go to their reset values immediately (asynchronously) and any pending load is lost.
- Decoder path is combinational. Segment data is valid in the same cycle as `anode`.

## Configuration
- Macro: `LED_SCAN_ZERO_BLANK_EN`.
- Defined: leading-zero blanking. Digit i (i = 1..3) is blanked when every nibble from i up to 3 of `dispVal` is 0, and its `dispDp` bit is also 0. Digit 0 is never blanked, so a value of 0 shows a single "0".
- Undefined: no blanking. All four digits are always lit outside dead time.

## Structure
- Shared header `led_defs.vh`:
  - `LED_DIGITS` = 4.
  - `LED_ANODE_OFF` = 4'b1111.
  - Nibble-width constant (4).
  - Default DIV/DEAD values.
- Sub-module `scan_prescaler`: parameterized modulo-DIV counter with `cnt` output and a `tick` output (high when `cnt == DIV-1`).
- Top-level holds `idx`, the shadow/display registers, blanking logic and output registers.

## Test plan
All scenarios use DIV=8, DEAD=2.
- Reset: hold `rst` 3 cycles → `anode=1111`, `N=0`, `dp=0`, `frame=0`. After release, `anode=1110` once `cnt=2`.
- Scan: load 16'h1A2F with `dpIn=4'b0100` → after the next `frame` pulse, slots show N=F,2,A,1 with anodes 1110,1101,1011,0111. `dp=1` only in slot 2. Each anode is low for exactly 6 of 8 cycles.
- Double load: load 16'h1111 then 16'h2222 within one frame → only 2222 is ever displayed, applied at the boundary.
- Boundary collision: `load` 16'hBEEF on the boundary edge → the next slot 0 shows N=F, and `pending=0`.
- Blanking with macro defined: load 16'h0007 → only `anode[0]` toggles and N=7. Without the macro, all four anodes cycle and N=0 for digits 1..3.
- Mid-frame reset: assert `rst` during slot 2 → all outputs go to reset values immediately. The shadow value is lost, and the display shows 0000 after release.
